// File: rtl/tx_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tx_framer
//  Description : Transmit framing stage ahead of the 8b/10b encoder. Wraps a
//                valid/ready/last byte stream in K27.7 / K29.7 delimiters,
//                fills underruns with K28.0, cuts over-length frames with a
//                K30.7 abort and emits K28.5 comma idles between frames.
//                One symbol (byte + K flag) is loaded per sym_en strobe.
//  Options     : TX_FRAMER_CRC_EN - append CRC-8 (poly 0x07, init 0x00,
//                MSB-first) after the last data byte of each normal frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_framer #(
    parameter int IDLE_MIN = 2,     // min K28.5 symbols between end and SOF (1..15)
    parameter int MAX_LEN  = 256    // max data bytes per frame (2..65535)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    input  logic       sym_en,
    output logic [7:0] data_out,
    output logic       k_out,
    output logic       frame_active,
    output logic       abort_pulse
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SOF   = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
`ifdef TX_FRAMER_CRC_EN
    localparam logic [2:0] c_ST_CRC   = 3'd3;
`endif
    localparam logic [2:0] c_ST_EOF   = 3'd4;
    localparam logic [2:0] c_ST_ABORT = 3'd5;
    localparam logic [2:0] c_ST_DROP  = 3'd6;

    // ------------------------------------------------------------------
    // Control character byte values (all sent with K = 1)
    // ------------------------------------------------------------------
    localparam logic [7:0] c_K28_5 = 8'hBC;   // comma idle
    localparam logic [7:0] c_K27_7 = 8'hFB;   // start of frame
    localparam logic [7:0] c_K28_0 = 8'h1C;   // in-frame underrun fill
    localparam logic [7:0] c_K29_7 = 8'hFD;   // end of frame
    localparam logic [7:0] c_K30_7 = 8'hFE;   // abort

    localparam logic [3:0]  c_IDLE_MIN = 4'(IDLE_MIN);
    localparam logic [15:0] c_MAX_LEN  = 16'(MAX_LEN);

    // ------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------
    logic [2:0]  state_q,    state_d;
    logic [3:0]  idle_cnt_q, idle_cnt_d;
    logic [15:0] len_q,      len_d;
    logic [7:0]  data_q,     data_d;
    logic        k_q,        k_d;
    logic        active_q,   active_d;
    logic        abort_q,    abort_d;
`ifdef TX_FRAMER_CRC_EN
    logic [7:0]  crc_q,      crc_d;
`endif

    logic        w_xfer;
    logic [15:0] w_len_inc;

`ifdef TX_FRAMER_CRC_EN
    // One byte of CRC-8, poly x^8+x^2+x+1, MSB first.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                             input logic [7:0] b);
        logic [7:0] r;
        r = crc ^ b;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        end
        return r;
    endfunction
`endif

    // Ready depends only on state and the strobe, never on s_valid.
    // DROP drains the rest of an aborted frame at full rate.
    assign s_ready   = ((state_q == c_ST_DATA) && sym_en) || (state_q == c_ST_DROP);
    assign w_xfer    = s_valid && s_ready;
    assign w_len_inc = len_q + 16'd1;

    assign data_out     = data_q;
    assign k_out        = k_q;
    assign frame_active = active_q;
    assign abort_pulse  = abort_q;

    // Next-state, counter and symbol selection; everything holds while sym_en is low.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        len_d      = len_q;
        data_d     = data_q;
        k_d        = k_q;
        active_d   = active_q;
        abort_d    = 1'b0;
`ifdef TX_FRAMER_CRC_EN
        crc_d      = crc_q;
`endif

        case (state_q)
            c_ST_IDLE: begin
                if (sym_en) begin
                    data_d   = c_K28_5;
                    k_d      = 1'b1;
                    active_d = 1'b0;
                    if (idle_cnt_q != c_IDLE_MIN) begin
                        idle_cnt_d = idle_cnt_q + 4'd1;
                    end
                    // Decision uses the count before this idle is added.
                    if (s_valid && (idle_cnt_q == c_IDLE_MIN)) begin
                        state_d = c_ST_SOF;
                    end
                end
            end

            c_ST_SOF: begin
                if (sym_en) begin
                    data_d   = c_K27_7;
                    k_d      = 1'b1;
                    active_d = 1'b1;
                    len_d    = 16'd0;
`ifdef TX_FRAMER_CRC_EN
                    crc_d    = 8'h00;
`endif
                    state_d  = c_ST_DATA;
                end
            end

            c_ST_DATA: begin
                if (sym_en) begin
                    active_d = 1'b1;
                    if (s_valid) begin
                        data_d = s_data;
                        k_d    = 1'b0;
                        len_d  = w_len_inc;
`ifdef TX_FRAMER_CRC_EN
                        crc_d  = crc8_byte(crc_q, s_data);
`endif
                        if (s_last) begin
`ifdef TX_FRAMER_CRC_EN
                            state_d = c_ST_CRC;
`else
                            state_d = c_ST_EOF;
`endif
                        end else if (w_len_inc == c_MAX_LEN) begin
                            state_d = c_ST_ABORT;
                        end
                    end else begin
                        // Underrun: fill without counting toward length.
                        data_d = c_K28_0;
                        k_d    = 1'b1;
                    end
                end
            end

`ifdef TX_FRAMER_CRC_EN
            c_ST_CRC: begin
                if (sym_en) begin
                    data_d   = crc_q;
                    k_d      = 1'b0;
                    active_d = 1'b1;
                    state_d  = c_ST_EOF;
                end
            end
`endif

            c_ST_EOF: begin
                if (sym_en) begin
                    data_d     = c_K29_7;
                    k_d        = 1'b1;
                    active_d   = 1'b1;
                    idle_cnt_d = 4'd0;
                    state_d    = c_ST_IDLE;
                end
            end

            c_ST_ABORT: begin
                if (sym_en) begin
                    data_d     = c_K30_7;
                    k_d        = 1'b1;
                    active_d   = 1'b1;
                    abort_d    = 1'b1;
                    idle_cnt_d = 4'd0;
                    state_d    = c_ST_DROP;
                end
            end

            c_ST_DROP: begin
                if (sym_en) begin
                    data_d     = c_K28_5;
                    k_d        = 1'b1;
                    active_d   = 1'b0;
                    idle_cnt_d = 4'd0;
                end
                // Leaving on the last discarded byte, strobe or not.
                if (w_xfer && s_last) begin
                    state_d = c_ST_IDLE;
                end
            end

            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // State, counters and the output symbol register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= c_ST_IDLE;
            idle_cnt_q <= 4'd0;
            len_q      <= 16'd0;
            data_q     <= c_K28_5;
            k_q        <= 1'b1;
            active_q   <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            len_q      <= len_d;
            data_q     <= data_d;
            k_q        <= k_d;
            active_q   <= active_d;
            abort_q    <= abort_d;
        end
    end

`ifdef TX_FRAMER_CRC_EN
    // Running CRC over the data bytes of the current frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tx_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_tx_framer
//  Description : Self-checking bench for tx_framer: directed per-cycle vector
//                table plus randomized frames checked by a symbol-stream model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_framer;

    localparam int IDLE_MIN = 2;
    localparam int MAX_LEN  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic       sym_en;
    logic [7:0] data_out;
    logic       k_out;
    logic       frame_active;
    logic       abort_pulse;

    always #5 clk = ~clk;

    tx_framer #(.IDLE_MIN(IDLE_MIN), .MAX_LEN(MAX_LEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .sym_en       (sym_en),
        .data_out     (data_out),
        .k_out        (k_out),
        .frame_active (frame_active),
        .abort_pulse  (abort_pulse)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // CRC-8 poly 0x07 by bit-serial long division, MSB first.
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[7] ^ b[i]) r = {r[6:0], 1'b0} ^ 8'h07;
            else             r = {r[6:0], 1'b0};
        end
        return r;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic       sym;
        logic       v;
        logic       l;
        logic [7:0] d;
        logic       rdy;
        logic [7:0] od;
        logic       ok;
        logic       oa;
        logic       oab;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic sym, input logic v, input logic l,
                                input logic [7:0] d, input logic rdy,
                                input logic [7:0] od, input logic ok,
                                input logic oa, input logic oab);
        vec_t t;
        t.sym = sym; t.v = v; t.l = l; t.d = d; t.rdy = rdy;
        t.od = od; t.ok = ok; t.oa = oa; t.oab = oab;
        vecs.push_back(t);
    endfunction

    // ---------------- random-phase model state ----------------
    logic [7:0] sb[$];      // bytes offered, in order
    logic       sl[$];      // last flag per byte
    int         sp[$];      // position of byte within its frame
    logic [8:0] exp_sym[$]; // expected {k,byte} excluding idles and fills
    int         idle_run;
    logic       in_frame;
    logic [7:0] prev_d;
    logic       prev_k, prev_a;

    // Classify one freshly loaded symbol against the expected stream.
    task automatic parse_symbol();
        logic [8:0] s;
        logic [8:0] e;
        s = {k_out, data_out};
        if (s == 9'h1BC) begin
            chk("idle outside frame", {31'b0, in_frame}, 0);
            chk("idle frame_active", {31'b0, frame_active}, 0);
            idle_run++;
        end else if (s == 9'h11C) begin
            chk("fill inside frame", {31'b0, in_frame}, 1);
            chk("fill frame_active", {31'b0, frame_active}, 1);
        end else begin
            if (s == 9'h1FB) begin
                chk("idle gap before SOF", (idle_run >= IDLE_MIN) ? 1 : 0, 1);
                in_frame = 1'b1;
            end
            chk("frame symbol active", {31'b0, frame_active}, 1);
            if (exp_sym.size() == 0) begin
                chk("extra symbol", {23'b0, s}, 9'h1BC);
            end else begin
                e = exp_sym.pop_front();
                chk("frame symbol", {23'b0, s}, {23'b0, e});
            end
            if (s == 9'h1FD || s == 9'h1FE) begin
                in_frame = 1'b0;
                idle_run = 0;
            end
        end
        chk("abort pulse", {31'b0, abort_pulse}, (s == 9'h1FE) ? 1 : 0);
    endtask

    initial begin
        logic [7:0] crc;
        int         len;
        int         idx;
        int         cyc;
        logic       mode3;
        logic       took;
        logic [7:0] b;

        rst_n = 1'b0; sym_en = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset data_out", {24'b0, data_out}, 8'hBC);
        chk("reset k_out", {31'b0, k_out}, 1);
        chk("reset frame_active", {31'b0, frame_active}, 0);
        chk("reset abort_pulse", {31'b0, abort_pulse}, 0);
        chk("reset s_ready", {31'b0, s_ready}, 0);
        rst_n = 1'b1;

        // Frame {11,22,33,44} with two fills, last on byte MAX_LEN (no abort).
        add(1,0,0,8'h00, 0, 8'hBC,1,0,0);
        add(1,1,0,8'h11, 0, 8'hBC,1,0,0);
        add(1,1,0,8'h11, 0, 8'hBC,1,0,0);
        add(1,1,0,8'h11, 0, 8'hFB,1,1,0);
        add(1,1,0,8'h11, 1, 8'h11,0,1,0);
        add(1,0,0,8'h00, 1, 8'h1C,1,1,0);
        add(1,0,0,8'h00, 1, 8'h1C,1,1,0);
        add(1,1,0,8'h22, 1, 8'h22,0,1,0);
        add(0,1,0,8'h33, 0, 8'h22,0,1,0);
        add(1,1,0,8'h33, 1, 8'h33,0,1,0);
        add(1,1,1,8'h44, 1, 8'h44,0,1,0);
`ifdef TX_FRAMER_CRC_EN
        crc = crc_step(crc_step(crc_step(crc_step(8'h00, 8'h11), 8'h22), 8'h33), 8'h44);
        add(1,0,0,8'h00, 0, crc,0,1,0);
`endif
        add(1,0,0,8'h00, 0, 8'hFD,1,1,0);
        add(1,0,0,8'h00, 0, 8'hBC,1,0,0);
        // Six-byte frame against MAX_LEN 4: abort then drain.
        add(1,1,0,8'hA1, 0, 8'hBC,1,0,0);
        add(1,1,0,8'hA1, 0, 8'hBC,1,0,0);
        add(1,1,0,8'hA1, 0, 8'hFB,1,1,0);
        add(1,1,0,8'hA1, 1, 8'hA1,0,1,0);
        add(1,1,0,8'hA2, 1, 8'hA2,0,1,0);
        add(1,1,0,8'hA3, 1, 8'hA3,0,1,0);
        add(1,1,0,8'hA4, 1, 8'hA4,0,1,0);
        add(0,1,0,8'hA5, 0, 8'hA4,0,1,0);
        add(1,1,0,8'hA5, 0, 8'hFE,1,1,1);
        add(0,1,0,8'hA5, 1, 8'hFE,1,1,0);
        add(1,1,1,8'hA6, 1, 8'hBC,1,0,0);
        add(1,0,0,8'h00, 0, 8'hBC,1,0,0);
        add(1,1,0,8'hB1, 0, 8'hBC,1,0,0);
        add(1,1,0,8'hB1, 0, 8'hBC,1,0,0);
        add(1,1,0,8'hB1, 0, 8'hFB,1,1,0);
        add(1,1,0,8'hB1, 1, 8'hB1,0,1,0);

        for (int i = 0; i < vecs.size(); i++) begin
            sym_en = vecs[i].sym; s_valid = vecs[i].v; s_last = vecs[i].l; s_data = vecs[i].d;
            @(negedge clk);
            chk($sformatf("vec%0d s_ready", i), {31'b0, s_ready}, {31'b0, vecs[i].rdy});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d data_out", i), {24'b0, data_out}, {24'b0, vecs[i].od});
            chk($sformatf("vec%0d k_out", i), {31'b0, k_out}, {31'b0, vecs[i].ok});
            chk($sformatf("vec%0d frame_active", i), {31'b0, frame_active}, {31'b0, vecs[i].oa});
            chk($sformatf("vec%0d abort_pulse", i), {31'b0, abort_pulse}, {31'b0, vecs[i].oab});
        end

        // Reset in the middle of a frame: ready drops at once, idles resume.
        sym_en = 1'b1; s_valid = 1'b1; s_last = 1'b0; s_data = 8'hB2;
        #1;
        chk("pre-reset s_ready", {31'b0, s_ready}, 1);
        rst_n = 1'b0;
        #1;
        chk("async reset s_ready", {31'b0, s_ready}, 0);
        chk("async reset data_out", {24'b0, data_out}, 8'hBC);
        chk("async reset frame_active", {31'b0, frame_active}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; s_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post-reset data_out", {24'b0, data_out}, 8'hBC);
        chk("post-reset k_out", {31'b0, k_out}, 1);

        // ---------------- randomized frames ----------------
        for (int f = 0; f < 24; f++) begin
            len = $urandom_range(1, 6);
            crc = 8'h00;
            exp_sym.push_back(9'h1FB);
            for (int j = 0; j < len; j++) begin
                b = 8'($urandom);
                sb.push_back(b);
                sl.push_back(j == len - 1);
                sp.push_back(j);
                if (j < MAX_LEN) exp_sym.push_back({1'b0, b});
                crc = crc_step(crc, b);
            end
            if (len <= MAX_LEN) begin
`ifdef TX_FRAMER_CRC_EN
                exp_sym.push_back({1'b0, crc});
`endif
                exp_sym.push_back(9'h1FD);
            end else begin
                exp_sym.push_back(9'h1FE);
            end
        end

        idle_run = 1;
        in_frame = 1'b0;
        prev_d = data_out; prev_k = k_out; prev_a = frame_active;
        idx = 0; cyc = 0; s_valid = 1'b0;
        while ((idx < sb.size() || exp_sym.size() > 0) && cyc < 8000) begin
            mode3  = (idx < sb.size() / 2);
            sym_en = mode3 ? ((cyc % 3) == 0) : 1'($urandom_range(0, 1));
            if (idx >= sb.size()) begin
                s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
            end else begin
                if (!s_valid) s_valid = ($urandom_range(0, 3) != 0);
                s_data = sb[idx]; s_last = sl[idx];
            end
            took = 1'b0;
            @(negedge clk);
            if (s_valid && s_ready) begin
                if (!sym_en) begin
                    chk("accept without strobe only when draining",
                        (sp[idx] >= MAX_LEN) ? 1 : 0, 1);
                end
                idx++;
                took = 1'b1;
            end
            @(posedge clk);
            #1;
            if (sym_en) begin
                parse_symbol();
            end else begin
                chk("hold data_out", {24'b0, data_out}, {24'b0, prev_d});
                chk("hold k_out", {31'b0, k_out}, {31'b0, prev_k});
                chk("hold frame_active", {31'b0, frame_active}, {31'b0, prev_a});
                chk("hold abort_pulse", {31'b0, abort_pulse}, 0);
            end
            prev_d = data_out; prev_k = k_out; prev_a = frame_active;
            if (took) s_valid = 1'b0;
            cyc++;
        end
        chk("random phase completed in budget", (cyc < 8000) ? 1 : 0, 1);
        chk("expected symbols remaining", exp_sym.size(), 0);
        chk("bytes remaining", sb.size() - idx, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tx_framer.md
# tx_framer

Transmit framing stage that sits directly upstream of the 8b/10b encoder. It accepts a byte stream with valid/ready/last handshaking and emits one byte plus K-flag per symbol slot. Between frames it inserts K28.5 comma idles. Each frame is wrapped in K27.7 start and K29.7 end delimiters, in-frame underruns are filled with K28.0, and over-length frames are cut with a K30.7 abort. The encoder and running-disparity logic consume `data_out`/`k_out` one symbol per `sym_en`.

## Interface
- `IDLE_MIN`, 2: minimum K28.5 symbols between an end/abort delimiter and the next SOF (1..15).
- `MAX_LEN`, 256: maximum data bytes per frame (2..65535).
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `s_data` in 8: payload byte.
- `s_valid` in 1: `s_data`/`s_last` valid.
- `s_last` in 1: current byte is the last of its frame.
- `s_ready` out 1: byte transfer occurs when `s_valid && s_ready`.
- `sym_en` in 1: symbol strobe from the encoder; a new symbol is loaded only on cycles where it is high.
- `data_out` out 8: symbol byte to the encoder.
- `k_out` out 1: 1 = control character.
- `frame_active` out 1: `data_out` currently holds SOF, data, fill, CRC, EOF or abort.
- `abort_pulse` out 1: one-cycle pulse on the cycle the abort symbol is loaded.

One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, SOF, DATA, CRC (macro only), EOF, ABORT, DROP.
- Symbol values: K28.5 = 0xBC/k1, K27.7 = 0xFB/k1, K28.0 = 0x1C/k1, K29.7 = 0xFD/k1, K30.7 = 0xFE/k1. Data bytes are sent with k0.
- **IDLE**
  - Each `sym_en` loads K28.5 and increments the idle counter, which saturates at `IDLE_MIN`.
  - Go to SOF when `s_valid` and the counter equals `IDLE_MIN` at a `sym_en`.
- **SOF**
  - Next `sym_en` loads K27.7 and clears the length counter. Go to DATA.
- **DATA**
  - `s_ready = sym_en`.
  - On a transfer: load `s_data` with k0 and increment the length counter.
  - On `sym_en` with `!s_valid`: load K28.0 fill. The fill is not counted toward length and the state stays DATA.
  - Transfer with `s_last`: go to EOF (or CRC when the macro is enabled).
  - Transfer without `s_last` that makes the length equal `MAX_LEN`: go to ABORT.
- **EOF**
  - Next `sym_en` loads K29.7. Clear the idle counter and go to IDLE.
- **ABORT**
  - Next `sym_en` loads K30.7 and pulses `abort_pulse`. Clear the idle counter and go to DROP.
- **DROP**
  - `s_ready = 1` regardless of `sym_en`. Accepted bytes are discarded.
  - Each `sym_en` loads K28.5, but the idle counter is held at 0.
  - Go to IDLE after a transfer with `s_last`.
- **`s_ready` in other states:** 0 in IDLE, SOF, CRC, EOF and ABORT.
- **Counter widths:** the length counter is 16 bits; the idle counter is 4 bits.

## Timing
- **Reset values:** `data_out` = 0xBC, `k_out` = 1, `frame_active` = 0, `abort_pulse` = 0, state IDLE, both counters 0.
  - `IDLE_MIN` idles are therefore required after reset before the first SOF.
- **Output register:** `data_out`, `k_out` and `frame_active` are registered and change only on the clock edge ending a `sym_en` cycle.
  - A byte accepted in cycle N is visible on `data_out` from cycle N+1.
- **`s_ready`:** combinational from the state and `sym_en`; there is no combinational path from `s_valid` to `s_ready`.
- **`sym_en` low:** all state, counters and outputs hold, except DROP acceptance.
- **SOF-to-data gap:** with `s_valid` held high, a frame's first data byte is loaded exactly one `sym_en` after SOF.
- **`s_last` on byte `MAX_LEN`:** the frame ends normally; there is no abort.
- **Reset mid-frame:** the frame is truncated with no EOF or abort. `s_ready` drops asynchronously and the next symbol after release is K28.5.

## Configuration
- **`TX_FRAMER_CRC_EN` defined:**
  - CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR) is computed over the data bytes of the current frame.
  - The CRC register is cleared at SOF.
  - After the last byte, the CRC state loads the CRC byte with k0 on the next `sym_en`, then EOF follows.
  - Aborted frames carry no CRC.
- **Undefined:** the CRC state and register are absent, and DATA goes directly to EOF.

## Test plan
- Reset, `sym_en` every cycle, no traffic -> `data_out` = 0xBC/k1 continuously, `frame_active` = 0, `s_ready` = 0.
- Frame {0x11, 0x22, 0x33} with `s_valid` high after the idles -> symbol sequence BC, BC, FB, 11, 22, 33, FD, BC...
  - Delimiters carry k1 and data carries k0.
  - `frame_active` is high from FB through FD.
- `s_valid` dropped for 2 `sym_en` mid-frame -> 1C, 1C inserted between data bytes; the length counter is unchanged.
- `MAX_LEN` = 4, 6-byte frame -> FB, 4 data bytes, FE with `abort_pulse`, remaining 2 bytes drained by DROP, then `IDLE_MIN` BC before the next FB.
- `sym_en` high every 3rd cycle -> exactly one symbol per strobe, `s_ready` only on strobe cycles, all bytes delivered in order.
- `TX_FRAMER_CRC_EN` set, frame {0x01} -> FB, 01, 07, FD.
- `TX_FRAMER_CRC_EN` set, frame {0x00} -> FB, 00, 00, FD.
